key_debounce_array: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 164 ++++++++++++++++
 rtl/key_debounce_array.sv | 41 ++++
 tb/tb_key_debounce_array.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debounce array.
// FSM state encoding and counter width sizing.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } key_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, debounce, press/release/long/repeat pulses.
// Latency: steady input change reaches o_level STABLE_CYCLES+2 edges after first sampling edge.
// Backpressure: none; pulses are single-cycle and not held. Auto-repeat via KEY_DEBOUNCE_ARRAY_REPEAT_EN.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 250000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic REL_LVL = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] STABLE_LAST = DW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic            level_q, level_d;
    key_state_e      state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            pressed_s;
    logic            rise;
    logic            fall;

    always_comb begin
        sync1_d   = i_in;
        sync2_d   = sync1_q;
        pressed_s = sync2_q ^ REL_LVL;
        deb_d     = '0;
        level_d   = level_q;
        rise      = 1'b0;
        fall      = 1'b0;
        // Toggle on the edge where the count would reach STABLE_CYCLES.
        if (pressed_s != level_q) begin
            if (deb_q >= STABLE_LAST) begin
                level_d = ~level_q;
                rise    = ~level_q;
                fall    = level_q;
            end else begin
                deb_d = deb_q + DW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = rise;
        release_d = fall;
        long_d    = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d = ST_RELEASED;
                    hold_d  = '0;
                end else if (hold_q >= LONG_LAST) begin
                    state_d = ST_HELD;
                    hold_d  = LONG_MAX;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_RELEASED;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= REL_LVL;
            sync2_q   <= REL_LVL;
            deb_q     <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_RELEASED;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

`ifdef KEY_DEBOUNCE_ARRAY_REPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          repeat_q, repeat_d;

    // Release wins over a coincident repeat so pulses stay exclusive.
    always_comb begin
        rep_d    = '0;
        repeat_d = 1'b0;
        if (state_q == ST_HELD && !fall) begin
            if (rep_q >= REP_LAST) begin
                repeat_d = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            repeat_q <= repeat_d;
        end
    end

    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: rtl/key_debounce_array.sv
// N independent debounced keys with press/release/long pulses; auto-repeat via KEY_DEBOUNCE_ARRAY_REPEAT_EN.
// Latency: STABLE_CYCLES+2 edges from input change to o_level/o_press.
// Backpressure: none; all outputs are single-cycle pulses or levels.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 250000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_in,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long,
    output logic [NUM_CH-1:0] o_repeat
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_in      (i_in[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g]),
            .o_repeat  (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: expected pulses are queued with their
// cycle number and matched against every pulse the DUT emits.
module tb_key_debounce_array;

    localparam int NCH    = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
    localparam int REP    = 3;
    localparam int LAT    = STABLE + 2;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [1:0]  ch;
    } ev_t;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] i_in;
    logic [NCH-1:0] o_level;
    logic [NCH-1:0] o_press;
    logic [NCH-1:0] o_release;
    logic [NCH-1:0] o_long;
    logic [NCH-1:0] o_repeat;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    ev_t exp_q[$];

    key_debounce_array #(
        .NUM_CH        (NCH),
        .ACTIVE_LOW    (1),
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_in      (i_in),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long),
        .o_repeat  (o_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int kind, input int ch);
        ev_t e;
        e.cyc  = 32'(c);
        e.kind = 2'(kind);
        e.ch   = 2'(ch);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every pulse seen must be the next expected event (same cycle, kind, channel).
    always @(negedge clk) begin
        logic [3:0] pv;
        ev_t got;
        ev_t want;
        for (int ch = 0; ch < NCH; ch++) begin
            pv = {o_repeat[ch], o_long[ch], o_release[ch], o_press[ch]};
            for (int k = 0; k < 4; k++) begin
                if (pv[k]) begin
                    got.cyc  = 32'(cyc);
                    got.kind = 2'(k);
                    got.ch   = 2'(ch);
                    if (exp_q.size() == 0) want = '1;
                    else want = exp_q.pop_front();
                    n_tests++;
                    assert (got === want)
                    else begin
                        n_fail++;
                        $error("FAIL event got cyc=%0d kind=%0d ch=%0d exp cyc=%0d kind=%0d ch=%0d",
                               got.cyc, got.kind, got.ch, want.cyc, want.kind, want.ch);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int d;
        int p;
        rst_n = 1'b0;
        i_in  = 2'b11;
        step(3);
        check("reset_outputs", {22'd0, o_level, o_press, o_release, o_long, o_repeat}, 32'd0);
        rst_n = 1'b1;
        step(3);
        check("idle_outputs", {22'd0, o_level, o_press, o_release, o_long, o_repeat}, 32'd0);

        // Clean long press on channel 0, released 20 cycles after the press pulse.
        c = cyc;
        i_in[0] = 1'b0;
        push(c + LAT, K_PRESS, 0);
        push(c + LAT + LONG, K_LONG, 0);
`ifdef KEY_DEBOUNCE_ARRAY_REPEAT_EN
        for (int t = c + LAT + LONG + REP; t < c + LAT + 20 + LAT; t += REP) push(t, K_REP, 0);
`endif
        push(c + LAT + 20 + LAT, K_REL, 0);
        step(LAT - 1);
        check("clean_level_before", 32'(o_level), 32'd0);
        step(1);
        check("clean_level_after", 32'(o_level), 32'd1);
        step(20);
        i_in[0] = 1'b1;
        step(LAT - 1);
        check("long_level_held", 32'(o_level), 32'd1);
        step(1);
        check("long_level_released", 32'(o_level), 32'd0);
        step(6);

        // Bounce: low 3, high 1, then held low; followed by a short press.
        c = cyc;
        i_in[0] = 1'b0;
        step(3);
        i_in[0] = 1'b1;
        step(1);
        i_in[0] = 1'b0;
        p = c + 4 + LAT;
        push(p, K_PRESS, 0);
        push(p + 2 + LAT, K_REL, 0);
        step(LAT - 1);
        check("bounce_level_before", 32'(o_level), 32'd0);
        step(1);
        check("bounce_level_after", 32'(o_level), 32'd1);
        step(2);
        i_in[0] = 1'b1;
        step(LAT);
        check("short_level_released", 32'(o_level), 32'd0);
        step(4);

        // Glitch of 3 synchronised cycles on channel 1 must be ignored.
        i_in[1] = 1'b0;
        step(3);
        i_in[1] = 1'b1;
        step(10);
        check("glitch_level", 32'(o_level), 32'd0);

        // Simultaneous press and release on both channels.
        c = cyc;
        i_in = 2'b00;
        push(c + LAT, K_PRESS, 0);
        push(c + LAT, K_PRESS, 1);
        push(c + 8 + LAT, K_REL, 0);
        push(c + 8 + LAT, K_REL, 1);
        step(LAT);
        check("dual_level_pressed", 32'(o_level), 32'd3);
        step(2);
        i_in = 2'b11;
        step(LAT);
        check("dual_level_released", 32'(o_level), 32'd0);
        step(4);

        // Reset while channel 1 is HELD, key kept low across reset.
        c = cyc;
        i_in[1] = 1'b0;
        push(c + LAT, K_PRESS, 1);
        push(c + LAT + LONG, K_LONG, 1);
        step(LAT + LONG + 2);
        check("held_level", 32'(o_level), 32'd2);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", {22'd0, o_level, o_press, o_release, o_long, o_repeat}, 32'd0);
        step(3);
        rst_n = 1'b1;
        d = cyc;
        push(d + LAT, K_PRESS, 1);
        push(d + LAT + LONG, K_LONG, 1);
`ifdef KEY_DEBOUNCE_ARRAY_REPEAT_EN
        for (int t = d + LAT + LONG + REP; t < d + 20 + LAT; t += REP) push(t, K_REP, 1);
`endif
        push(d + 20 + LAT, K_REL, 1);
        step(LAT - 1);
        check("rearm_level_before", 32'(o_level), 32'd0);
        step(1);
        check("rearm_level_after", 32'(o_level), 32'd2);
        step(20 - LAT);
        i_in[1] = 1'b1;
        step(LAT);
        check("rearm_level_released", 32'(o_level), 32'd0);
        step(10);

        check("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
